// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Round-robin on contention; each transfer runs grant -> response -> idle.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   grant_if;
  logic   grant_dm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only IDLE arbitrates; on contention the side not served last time wins.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && dm_req) begin
          if (last_grant) begin
            grant_if = 1'b1;
          end else begin
            grant_dm = 1'b1;
          end
        end else if (dm_req) begin
          grant_dm = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_if) begin
          state_next = GNT_IF;
        end else if (grant_dm) begin
          state_next = GNT_DM;
        end
      end
      GNT_IF: begin
        if (mem_ack) begin
          state_next = RESP;
        end
      end
      GNT_DM: begin
        if (mem_ack) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req = (state == GNT_IF) || (state == GNT_DM);

  // Memory-side request fields are latched once at grant time so they stay
  // stable for the whole transfer regardless of what the requesters do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_ctrl   <= 3'd0;
    end else if (grant_if) begin
      last_grant <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= if_addr;
      mem_wdata  <= 32'd0;
      mem_ctrl   <= 3'b010;
    end else if (grant_dm) begin
      last_grant <= 1'b1;
      mem_we     <= dm_we;
      mem_addr   <= dm_addr;
      mem_wdata  <= dm_wdata;
      mem_ctrl   <= dm_ctrl;
    end
  end

  // Ready is set on the ack edge, so it is high exactly during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_rdata <= 32'd0;
      dm_rdata <= 32'd0;
    end else begin
      if_ready <= (state == GNT_IF) && mem_ack;
      dm_ready <= (state == GNT_DM) && mem_ack;
      if ((state == GNT_IF) && mem_ack) begin
        if_rdata <= mem_rdata;
      end
      if ((state == GNT_DM) && mem_ack) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic compared cycle by cycle against a transaction model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total_checks = 0;
  int bad_checks   = 0;

  // Transaction model: phase 0 = waiting, 1 = transfer on the port, 2 = reply
  int          m_phase;
  bit          m_for_dm;
  bit          m_last_dm;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_ctrl;
  logic [31:0] m_if_data;
  logic [31:0] m_dm_data;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ctrl   (dm_ctrl),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ctrl  (mem_ctrl),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit expIfReady();
    return (m_phase == 2) && !m_for_dm;
  endfunction

  function automatic bit expDmReady();
    return (m_phase == 2) && m_for_dm;
  endfunction

  task automatic modelReset();
    m_phase   = 0;
    m_for_dm  = 1'b0;
    m_last_dm = 1'b1;
    m_we      = 1'b0;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    m_ctrl    = 3'd0;
    m_if_data = 32'd0;
    m_dm_data = 32'd0;
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic modelUpdate();
    bit serve_dm;
    case (m_phase)
      0: begin
        if (if_req || dm_req) begin
          serve_dm  = (if_req && dm_req) ? !m_last_dm : dm_req;
          m_phase   = 1;
          m_for_dm  = serve_dm;
          m_last_dm = serve_dm;
          if (serve_dm) begin
            m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_ctrl = dm_ctrl;
          end else begin
            m_we = 1'b0; m_addr = if_addr; m_wdata = 32'd0; m_ctrl = 3'b010;
          end
        end
      end
      1: begin
        if (mem_ack) begin
          m_phase = 2;
          if (m_for_dm) m_dm_data = mem_rdata;
          else          m_if_data = mem_rdata;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic checkRegs();
    checkOutput("mem_req",   32'(mem_req),   32'(m_phase == 1));
    checkOutput("mem_we",    32'(mem_we),    32'(m_we));
    checkOutput("mem_addr",  mem_addr,       m_addr);
    checkOutput("mem_wdata", mem_wdata,      m_wdata);
    checkOutput("mem_ctrl",  32'(mem_ctrl),  32'(m_ctrl));
    checkOutput("if_ready",  32'(if_ready),  32'(expIfReady()));
    checkOutput("dm_ready",  32'(dm_ready),  32'(expDmReady()));
    checkOutput("if_rdata",  if_rdata,       m_if_data);
    checkOutput("dm_rdata",  dm_rdata,       m_dm_data);
  endtask

  // Inputs are already driven; check the stall paths, cross one edge, recheck.
  task automatic stepCycle();
    #1;
    checkOutput("if_stall", 32'(if_stall), 32'(if_req & ~expIfReady()));
    checkOutput("dm_stall", 32'(dm_stall), 32'(dm_req & ~expDmReady()));
    @(posedge clk);
    if (!reset) modelUpdate();
    @(negedge clk);
    checkRegs();
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkRegs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkRegs();
  endtask

  task automatic applyStimulus();
    if (!if_req || expIfReady()) begin
      if_req  = ($urandom_range(0, 1) == 1);
      if_addr = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 15) == 0) begin
      if_req  = ($urandom_range(0, 1) == 1);
      if_addr = $urandom;
    end
    if (!dm_req || expDmReady()) begin
      dm_req   = ($urandom_range(0, 1) == 1);
      dm_we    = ($urandom_range(0, 1) == 1);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      dm_ctrl  = 3'($urandom_range(0, 7));
    end else if ($urandom_range(0, 15) == 0) begin
      dm_req   = ($urandom_range(0, 1) == 1);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    mem_ack   = ($urandom_range(0, 2) == 0);
    mem_rdata = $urandom;
  endtask

  initial begin
    int grants;
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'd0; dm_wdata = 32'd0; dm_ctrl = 3'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    doReset();

    // Single fetch with ack two cycles after mem_req rises, then spurious acks.
    if_req = 1'b1; if_addr = 32'h0000_0010;
    stepCycle();
    checkOutput("fetch_addr", mem_addr, 32'h10);
    stepCycle();
    stepCycle();
    mem_ack = 1'b1; mem_rdata = 32'h0100_0293;
    stepCycle();
    checkOutput("fetch_ready", 32'(if_ready), 32'd1);
    if_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    stepCycle();
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("fetch_rdata", if_rdata, 32'h0100_0293);
    checkOutput("fetch_noready", 32'(if_ready), 32'd0);

    // Contention from reset with immediate ack: strict IF/DM alternation.
    doReset();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd0; dm_wdata = 32'h10; dm_ctrl = 3'b010;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    grants = 0;
    for (int i = 0; i < 18; i++) begin
      stepCycle();
      if (mem_req) begin
        checkOutput("grant_order", 32'(mem_we), 32'(grants % 2));
        if (grants % 2 == 1) checkOutput("cont_wdata", mem_wdata, 32'h10);
        grants++;
      end
    end
    checkOutput("grant_count", 32'(grants), 32'd6);
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;

    // Reset landing in the middle of a data transfer.
    doReset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    stepCycle();
    stepCycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mem_req",  32'(mem_req),  32'd0);
    checkOutput("rst_dm_ready", 32'(dm_ready), 32'd0);
    checkOutput("rst_if_rdata", if_rdata,      32'd0);
    checkOutput("rst_dm_rdata", dm_rdata,      32'd0);
    modelReset();
    dm_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkRegs();

    // Randomized traffic, with occasional asynchronous reset mid-transfer.
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == 1 && $urandom_range(0, 99) < 3) begin
        reset = 1'b1;
        #1;
        checkOutput("rnd_rst_mem_req", 32'(mem_req), 32'd0);
        modelReset();
        checkRegs();
        stepCycle();
        reset = 1'b0;
      end
      applyStimulus();
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
